load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory stage of the 16-bit MIPS datapath for lw/sw. Sits directly downstream of the
//  execute ALU: consumes the ALU result as byte address and register-file read data 2 as
//  store data, and runs a req/ack handshake to a word-organised data memory. Stalls the
//  CPU until the access completes, errors out, or times out.
// PARAMETERS
//  ADDR_W   9   data-memory word-address width (512 x 16-bit words)
//  TIMEOUT  15  max cycles in BUSY waiting for dmem_ack before bus error (>=1)
// PORTS
//  clk         in   1       single clock, rising-edge
//  rst         in   1       asynchronous, active-high reset
//  mem_read    in   1       lw decoded by main control (level, held while instr held)
//  mem_write   in   1       sw decoded by main control
//  addr        in   16      byte address (ALU result)
//  wdata       in   16      store data (rd2)
//  rdata       out  16      load result to write-back mux
//  stall       out  1       CPU must hold PC and IR while 1
//  err         out  1       1-cycle pulse: misaligned/out-of-range/illegal/timeout
//  dmem_req    out  1       memory request, held until ack
//  dmem_we     out  1       1 = write, 0 = read; valid while dmem_req
//  dmem_addr   out  ADDR_W  word address = addr[ADDR_W:1]
//  dmem_wdata  out  16      store data, valid while dmem_req
//  dmem_rdata  in   16      read data, sampled on cycle dmem_ack=1
//  dmem_ack    in   1       access complete; 1 cycle
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  Reset (async, immediate): state=IDLE, rdata=0, err=0, dmem_req=0, dmem_we=0,
//   dmem_addr=0, dmem_wdata=0, timeout counter=0; stall=0. Reset mid-access abandons it.
//  States: IDLE, BUSY, DONE.
//  IDLE: access = mem_read|mem_write.
//   - mem_read&mem_write: illegal -> err pulse next cycle, no request, stay IDLE.
//   - addr[0]=1 (misaligned) or addr[15:ADDR_W+1]!=0 (out of range): err pulse next
//     cycle, no request, stall=0, stay IDLE.
//   - valid access: stall=1 combinationally this cycle; on edge latch dmem_addr, dmem_we,
//     dmem_wdata, assert dmem_req, clear counter, go BUSY.
//  BUSY: stall=1, dmem_req=1, address/data/we stable. Counter increments each cycle.
//   - dmem_ack=1: on edge drop dmem_req; if read, rdata<=dmem_rdata; go DONE.
//   - counter reaches TIMEOUT with no ack: drop dmem_req, err pulse, rdata<=0 if read,
//     go DONE. Ack and timeout same cycle: ack wins, no err.
//  DONE: stall=0 for exactly one cycle so CPU advances PC; mem_read/mem_write ignored
//   (prevents relaunch of same instruction); next state IDLE.
//  Minimum latency: valid access with ack in first BUSY cycle -> stall high 2 cycles.
//  rdata holds last completed load value; stores and errors (except read timeout) don't
//   change it. dmem_ack outside BUSY ignored. err is registered, never 2 cycles wide
//   for one event. Counter width clog2(TIMEOUT+1), saturates, no wrap.
// TESTING
//  1 sw addr=0x0004 wdata=0x1234, ack on 2nd BUSY cycle -> dmem_addr=2, dmem_we=1,
//    dmem_wdata=0x1234, req 2 cycles, stall 3 cycles, err=0, rdata unchanged.
//  2 lw addr=0x0004, ack on 1st BUSY cycle with dmem_rdata=0xBEEF -> rdata=0xBEEF
//    in DONE, stall low in DONE, rdata held across following non-load instructions.
//  3 lw addr=0x0003 -> no dmem_req, stall=0, err=1 for exactly one cycle; same for
//    addr=0x0400 (out of range, ADDR_W=9) and mem_read=mem_write=1.
//  4 lw addr=0x0010, dmem_ack never -> after 15 BUSY cycles err pulse, req drops,
//    rdata=0, DONE then IDLE; late ack in IDLE ignored.
//  5 rst asserted mid-BUSY (no clock edge) -> dmem_req, stall, rdata to 0 at once;
//    after release, sw addr=0x0002 completes normally with dmem_addr=1.
//  6 back-to-back lw 0x0002 then sw 0x0006 -> DONE separates them, exactly one req per
//    instruction, ack coincident with timeout -> no err.

Source files
------------

// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : load_store_unit                                            |
// | Description : Memory stage for lw/sw. Converts the ALU byte address into |
// |               a word address, rejects illegal, misaligned and            |
// |               out-of-range accesses, and runs a req/ack handshake with a |
// |               bus timeout while stalling the CPU.                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module load_store_unit #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [15:0]       addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata,
    output logic              stall,
    output logic              err,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [15:0]       dmem_wdata,
    input  logic [15:0]       dmem_rdata,
    input  logic              dmem_ack
);

    localparam int                 c_CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_access;
    logic               w_bad;
    logic               w_launch;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               w_timeout;

    // Decode the request and classify it as launchable or faulty.
    always_comb begin
        w_access   = mem_read | mem_write;
        // Illegal both-set, odd byte address, or any address bit above the word range.
        w_bad      = (mem_read & mem_write) | addr[0] | (|(addr >> (ADDR_W + 1)));
        w_launch   = (r_state == c_IDLE) & w_access & ~w_bad;
        // Saturating wait counter; a timeout fires on the TIMEOUT-th busy cycle.
        w_cnt_next = (r_cnt == c_TIMEOUT) ? r_cnt : r_cnt + 1'b1;
        w_timeout  = (w_cnt_next == c_TIMEOUT);
        // Stall covers the launch cycle (combinational) plus every busy cycle;
        // reset forces it low immediately even if the instruction is still held.
        stall      = ~rst & ((r_state == c_BUSY) | w_launch);
    end

    // Access FSM with registered bus signals, load result and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            rdata      <= '0;
            err        <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_access) begin
                        if (w_bad) begin
                            err <= 1'b1;
                        end else begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_write;
                            dmem_addr  <= addr[ADDR_W:1];
                            dmem_wdata <= wdata;
                            r_cnt      <= '0;
                            r_state    <= c_BUSY;
                        end
                    end
                end
                c_BUSY: begin
                    r_cnt <= w_cnt_next;
                    // Ack takes priority over a coincident timeout.
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (!dmem_we) rdata <= dmem_rdata;
                        r_state  <= c_DONE;
                    end else if (w_timeout) begin
                        dmem_req <= 1'b0;
                        err      <= 1'b1;
                        if (!dmem_we) rdata <= '0;
                        r_state  <= c_DONE;
                    end
                end
                // One free cycle so the CPU advances; the held request is ignored.
                c_DONE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_load_store_unit                                         |
// | Description : Directed self-checking bench for load_store_unit with a    |
// |               transaction-level reference model and per-cycle compare.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_load_store_unit;

    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_read, mem_write;
    logic [15:0]       addr, wdata, rdata;
    logic              stall, err, dmem_req, dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [15:0]       dmem_wdata, dmem_rdata;
    logic              dmem_ack;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .err(err),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Legal access: exactly one of read/write, even address, inside 2*2^ADDR_W bytes.
    function automatic bit req_ok(input logic rd, input logic wr, input logic [15:0] a);
        return (rd != wr) && (a % 2 == 0) && (int'(a) < 2 * (1 << ADDR_W));
    endfunction

    // Reference model: a request in flight, how long it has waited, and a
    // one-cycle completion gap before the next instruction may launch.
    bit                m_busy, m_after, m_read, m_we, m_err;
    int                m_wait;
    logic [ADDR_W-1:0] m_addr;
    logic [15:0]       m_wdata, m_rdata;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 0; m_after <= 0; m_read <= 0; m_we <= 0; m_err <= 0;
            m_wait <= 0; m_addr <= '0; m_wdata <= '0; m_rdata <= '0;
        end else begin
            m_err <= 0;
            if (m_busy) begin
                m_wait <= m_wait + 1;
                if (dmem_ack) begin
                    m_busy <= 0; m_after <= 1;
                    if (m_read) m_rdata <= dmem_rdata;
                end else if (m_wait + 1 >= TIMEOUT) begin
                    m_busy <= 0; m_after <= 1; m_err <= 1;
                    if (m_read) m_rdata <= '0;
                end
            end else if (m_after) begin
                m_after <= 0;
            end else if (mem_read || mem_write) begin
                if (req_ok(mem_read, mem_write, addr)) begin
                    m_busy <= 1; m_wait <= 0; m_read <= mem_read; m_we <= mem_write;
                    m_addr <= ADDR_W'(addr / 2); m_wdata <= wdata;
                end else begin
                    m_err <= 1;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("stall", stall, m_busy || (!m_after && req_ok(mem_read, mem_write, addr)));
            chk("dmem_req", dmem_req, m_busy);
            chk("err", err, m_err);
            chk("rdata", rdata, m_rdata);
            if (m_busy) begin
                chk("dmem_we", dmem_we, m_we);
                chk("dmem_addr", dmem_addr, m_addr);
                chk("dmem_wdata", dmem_wdata, m_wdata);
            end
        end
    end

    // Per-instruction observations.
    int                t_stall, t_rise, t_reqcyc, t_err;
    logic [ADDR_W-1:0] t_addr;
    logic              t_we;
    logic [15:0]       t_wd;

    // Hold one instruction until stall drops; ack on busy cycle ack_cyc (0 = never).
    task automatic run_instr(input logic rd, input logic wr, input logic [15:0] a,
                             input logic [15:0] wd, input int ack_cyc,
                             input logic [15:0] rv, input bit trail);
        bit   done = 0;
        logic prev = 0;
        t_stall = 0; t_rise = 0; t_reqcyc = 0; t_err = 0;
        t_addr = '0; t_we = 0; t_wd = '0;
        mem_read = rd; mem_write = wr; addr = a; wdata = wd;
        for (int c = 0; c < 40 && !done; c++) begin
            dmem_ack   = (ack_cyc != 0) && (c == ack_cyc);
            dmem_rdata = rv;
            @(negedge clk);
            if (stall) t_stall++;
            if (err) t_err++;
            if (dmem_req && !prev) t_rise++;
            if (dmem_req) begin
                t_reqcyc++; t_addr = dmem_addr; t_we = dmem_we; t_wd = dmem_wdata;
            end
            prev = dmem_req;
            if (!stall) done = 1;
            @(posedge clk); #1;
        end
        chk("instr_completes", done, 1);
        mem_read = 0; mem_write = 0; dmem_ack = 0;
        if (trail) begin
            @(negedge clk);
            if (err) t_err++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; mem_read = 0; mem_write = 0; addr = '0; wdata = '0;
        dmem_rdata = '0; dmem_ack = 0;
        #2;
        chk("rst_rdata", rdata, 16'h0);
        chk("rst_stall", stall, 0);
        chk("rst_err", err, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        @(posedge clk); #1; rst = 0;
        @(posedge clk); #1;

        // sw 0x0004, ack on second busy cycle
        run_instr(0, 1, 16'h0004, 16'h1234, 2, 16'hDEAD, 1);
        chk("t1_addr", t_addr, 2);
        chk("t1_we", t_we, 1);
        chk("t1_wdata", t_wd, 16'h1234);
        chk("t1_reqcyc", t_reqcyc, 2);
        chk("t1_stall", t_stall, 3);
        chk("t1_err", t_err, 0);
        chk("t1_rdata", rdata, 16'h0000);

        // lw 0x0004, ack on first busy cycle, then a store must not disturb rdata
        run_instr(1, 0, 16'h0004, 16'h0, 1, 16'hBEEF, 0);
        chk("t2_rdata", rdata, 16'hBEEF);
        chk("t2_stall", t_stall, 2);
        run_instr(0, 1, 16'h0008, 16'h7777, 1, 16'hAAAA, 1);
        chk("t2_hold", rdata, 16'hBEEF);

        // reset in the middle of a busy load
        mem_read = 1; addr = 16'h0020;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst = 1;
        #1;
        chk("t5_req", dmem_req, 0);
        chk("t5_stall", stall, 0);
        chk("t5_rdata", rdata, 16'h0);
        @(posedge clk); #3 rst = 0; mem_read = 0;
        @(posedge clk); #1;
        run_instr(0, 1, 16'h0002, 16'h5A5A, 1, 16'h0, 1);
        chk("t5_addr", t_addr, 1);
        chk("t5_rise", t_rise, 1);
        chk("t5_err", t_err, 0);

        // faulty accesses: misaligned, out of range, both strobes
        run_instr(1, 0, 16'h0003, 16'h0, 0, 16'h0, 1);
        chk("t3a_rise", t_rise, 0);
        chk("t3a_stall", t_stall, 0);
        chk("t3a_err", t_err, 1);
        run_instr(1, 0, 16'h0400, 16'h0, 0, 16'h0, 1);
        chk("t3b_rise", t_rise, 0);
        chk("t3b_err", t_err, 1);
        run_instr(1, 1, 16'h0004, 16'h0, 0, 16'h0, 1);
        chk("t3c_rise", t_rise, 0);
        chk("t3c_err", t_err, 1);
        // highest legal word
        run_instr(1, 0, 16'h03FE, 16'h0, 1, 16'h0F0F, 1);
        chk("top_addr", t_addr, 9'h1FF);
        chk("top_rdata", rdata, 16'h0F0F);

        // load that never gets an ack
        run_instr(1, 0, 16'h0010, 16'h0, 0, 16'h0, 1);
        chk("t4_reqcyc", t_reqcyc, 15);
        chk("t4_stall", t_stall, 16);
        chk("t4_err", t_err, 1);
        chk("t4_rdata", rdata, 16'h0);
        dmem_ack = 1; dmem_rdata = 16'h5555;
        @(posedge clk); #1; dmem_ack = 0;
        @(negedge clk);
        chk("t4_late_rdata", rdata, 16'h0);
        chk("t4_late_req", dmem_req, 0);
        @(posedge clk); #1;

        // back-to-back load then store; store ack coincides with timeout
        run_instr(1, 0, 16'h0002, 16'h0, 1, 16'h1111, 0);
        chk("t6a_rise", t_rise, 1);
        run_instr(0, 1, 16'h0006, 16'hCAFE, 15, 16'h2222, 1);
        chk("t6b_rise", t_rise, 1);
        chk("t6b_reqcyc", t_reqcyc, 15);
        chk("t6b_err", t_err, 0);
        chk("t6b_addr", t_addr, 3);
        chk("t6_rdata", rdata, 16'h1111);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
